// File: rtl/aes_block_ctrl.sv
// aes_block_ctrl
//
// Sequences one 128-bit plaintext block at a time through a word-serial AES
// core. It loads the block as four 32-bit words with a one-cycle active-low
// start strobe, then waits for a fresh rising edge on the core's done level.
// It then issues a one-cycle active-low read trigger, skips one gap cycle and
// captures four ciphertext words. The result is held until the consumer takes
// it. If done never rises within DONE_TIMEOUT wait cycles, the block is
// abandoned and a sticky error is raised.
//
// Parameters
//   DONE_TIMEOUT     max cycles spent waiting for done (16..65535)
// Ports
//   clk              system clock, rising edge active
//   reset            asynchronous active-high reset
//   in_valid         plaintext block offered
//   in_ready         controller accepts a block (high only when idle)
//   in_block         plaintext, word0 = [127:96] .. word3 = [31:0]
//   out_valid        ciphertext block available
//   out_ready        consumer takes the block
//   out_block        ciphertext, word0 = [127:96]
//   aes_start_n      active-low start strobe to the core (first load cycle)
//   aes_start_read_n active-low read trigger to the core
//   aes_dword_in     word stream to the core (zero outside loading)
//   aes_dword_out    word stream from the core
//   aes_done         core completion level
//   busy             high whenever a block is in flight
//   timeout_err      sticky abort flag, cleared by the next accepted block
module aes_block_ctrl #(
  parameter int DONE_TIMEOUT = 512
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_block,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_block,
  output logic         aes_start_n,
  output logic         aes_start_read_n,
  output logic [31:0]  aes_dword_in,
  input  logic [31:0]  aes_dword_out,
  input  logic         aes_done,
  output logic         busy,
  output logic         timeout_err
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] LOAD      = 3'd1;
  localparam logic [2:0] WAIT_DONE = 3'd2;
  localparam logic [2:0] READ_REQ  = 3'd3;
  localparam logic [2:0] READ_GAP  = 3'd4;
  localparam logic [2:0] READ      = 3'd5;
  localparam logic [2:0] HOLD      = 3'd6;

  // Last value of the wait counter before giving up: the wait state then
  // lasts exactly DONE_TIMEOUT cycles.
  localparam logic [15:0] TIMEOUT_LAST = 16'(DONE_TIMEOUT - 1);

  logic [2:0]   state;
  logic [127:0] block;      // latched plaintext, immune to in_block changes
  logic [1:0]   word_cnt;   // word index during LOAD and READ
  logic [15:0]  wait_cnt;
  logic         done_q;     // single register stage on the done level
  logic         seen_low;   // done has been observed low since entering WAIT_DONE
  logic [95:0]  cap;        // first three captured ciphertext words
  logic [31:0]  next_word;

  // aes_dword_in is registered, so while in LOAD cycle k the next value to
  // present is word k+1.
  always_comb begin
    next_word = block[31:0];
    case (word_cnt)
      2'd0:    next_word = block[95:64];
      2'd1:    next_word = block[63:32];
      default: next_word = block[31:0];
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      block            <= '0;
      word_cnt         <= '0;
      wait_cnt         <= '0;
      done_q           <= 1'b0;
      seen_low         <= 1'b0;
      cap              <= '0;
      in_ready         <= 1'b1;
      out_valid        <= 1'b0;
      out_block        <= '0;
      aes_start_n      <= 1'b1;
      aes_start_read_n <= 1'b1;
      aes_dword_in     <= '0;
      busy             <= 1'b0;
      timeout_err      <= 1'b0;
    end else begin
      done_q <= aes_done;
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            block        <= in_block;
            state        <= LOAD;
            in_ready     <= 1'b0;
            busy         <= 1'b1;
            timeout_err  <= 1'b0;
            aes_start_n  <= 1'b0;
            aes_dword_in <= in_block[127:96];
            word_cnt     <= 2'd0;
          end
        end

        LOAD: begin
          aes_start_n <= 1'b1;
          word_cnt    <= word_cnt + 2'd1;
          if (word_cnt == 2'd3) begin
            aes_dword_in <= '0;
            state        <= WAIT_DONE;
            wait_cnt     <= '0;
            seen_low     <= 1'b0;
          end else begin
            aes_dword_in <= next_word;
          end
        end

        WAIT_DONE: begin
          // A done level that was already high on entry only counts after it
          // has been seen low inside this state.
          seen_low <= seen_low | ~done_q;
          if (seen_low && done_q) begin
            state            <= READ_REQ;
            aes_start_read_n <= 1'b0;
          end else if (wait_cnt == TIMEOUT_LAST) begin
            state       <= IDLE;
            timeout_err <= 1'b1;
            in_ready    <= 1'b1;
            busy        <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end

        READ_REQ: begin
          aes_start_read_n <= 1'b1;
          state            <= READ_GAP;
        end

        READ_GAP: begin
          state    <= READ;
          word_cnt <= 2'd0;
        end

        READ: begin
          word_cnt <= word_cnt + 2'd1;
          if (word_cnt == 2'd3) begin
            // out_block only changes here, so it stays stable while held.
            out_block <= {cap, aes_dword_out};
            out_valid <= 1'b1;
            state     <= HOLD;
          end else begin
            cap <= {cap[63:0], aes_dword_out};
          end
        end

        HOLD: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end

        default: begin
          state            <= IDLE;
          in_ready         <= 1'b1;
          busy             <= 1'b0;
          out_valid        <= 1'b0;
          aes_start_n      <= 1'b1;
          aes_start_read_n <= 1'b1;
          aes_dword_in     <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_block_ctrl.sv
// Directed testbench for aes_block_ctrl. Two instances share every input:
// one with a 32-cycle done timeout and one with the default 512, so that the
// stale-done scenario can wait far longer than 32 cycles. A behavioural core
// model is attached to whichever instance sel_long selects.
module tb_aes_block_ctrl;

  localparam logic [127:0] B_ONES   = {128{1'b1}};
  localparam logic [127:0] B_SEQ    = 128'h00112233_44556677_8899aabb_ccddeeff;
  localparam logic [127:0] B_JUNK   = 128'hdeadbeef_01234567_89abcdef_cafef00d;
  localparam logic [127:0] NIST_CT  = 128'h3f5b8cc9_ea855a0a_fa7347d2_3e8d664e;
  localparam logic [127:0] SEQ_CT   = 128'ha5b48796_e1f0c3d2_2d3c0f1e_69784b5a;
  localparam int           CORE_LAT = 10;

  logic         clk;
  logic         reset;
  logic         in_valid;
  logic [127:0] in_block;
  logic         out_ready;
  logic [31:0]  aes_dword_out;
  logic         aes_done;

  logic         s_in_ready, s_out_valid, s_start_n, s_start_read_n, s_busy, s_timeout_err;
  logic [127:0] s_out_block;
  logic [31:0]  s_dword_in;
  logic         l_in_ready, l_out_valid, l_start_n, l_start_read_n, l_busy, l_timeout_err;
  logic [127:0] l_out_block;
  logic [31:0]  l_dword_in;

  logic         sel_long;
  logic         m_in_ready, m_out_valid, m_start_n, m_start_read_n, m_busy, m_timeout_err;
  logic [127:0] m_out_block;
  logic [31:0]  m_dword_in;

  assign m_in_ready     = sel_long ? l_in_ready     : s_in_ready;
  assign m_out_valid    = sel_long ? l_out_valid    : s_out_valid;
  assign m_start_n      = sel_long ? l_start_n      : s_start_n;
  assign m_start_read_n = sel_long ? l_start_read_n : s_start_read_n;
  assign m_busy         = sel_long ? l_busy         : s_busy;
  assign m_timeout_err  = sel_long ? l_timeout_err  : s_timeout_err;
  assign m_out_block    = sel_long ? l_out_block    : s_out_block;
  assign m_dword_in     = sel_long ? l_dword_in     : s_dword_in;

  aes_block_ctrl #(.DONE_TIMEOUT(32)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_block(in_block), .out_valid(s_out_valid), .out_ready(out_ready),
    .out_block(s_out_block), .aes_start_n(s_start_n), .aes_start_read_n(s_start_read_n),
    .aes_dword_in(s_dword_in), .aes_dword_out(aes_dword_out), .aes_done(aes_done),
    .busy(s_busy), .timeout_err(s_timeout_err)
  );

  aes_block_ctrl #(.DONE_TIMEOUT(512)) dut_long (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(l_in_ready),
    .in_block(in_block), .out_valid(l_out_valid), .out_ready(out_ready),
    .out_block(l_out_block), .aes_start_n(l_start_n), .aes_start_read_n(l_start_read_n),
    .aes_dword_in(l_dword_in), .aes_dword_out(aes_dword_out), .aes_done(aes_done),
    .busy(l_busy), .timeout_err(l_timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- core model ----------------
  // Key-0 AES for the all-ones block (known answer); any other block is
  // "encrypted" by XOR with a5a5a5a5 in every word.
  function automatic logic [127:0] core_fn(input logic [127:0] b);
    if (b == B_ONES) return NIST_CT;
    return b ^ {4{32'ha5a5a5a5}};
  endfunction

  logic [127:0] core_in;
  logic [127:0] core_res;
  int           core_wcnt;
  int           core_lat;
  int           rd_idx;
  logic         core_done;
  logic         done_enable;
  logic         done_force;
  logic         done_force_val;

  assign core_res = core_fn(core_in);
  assign aes_done = done_force ? done_force_val : core_done;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      core_wcnt     <= 0;
      core_lat      <= 0;
      rd_idx        <= 4;
      core_done     <= 1'b0;
      aes_dword_out <= '0;
    end else begin
      if (!m_start_n) begin
        core_in[127:96] <= m_dword_in;
        core_wcnt       <= 1;
        core_lat        <= 0;
        core_done       <= 1'b0;
      end else if (core_wcnt >= 1 && core_wcnt <= 3) begin
        core_in[127 - 32*core_wcnt -: 32] <= m_dword_in;
        core_wcnt <= core_wcnt + 1;
      end else if (core_wcnt == 4 && done_enable) begin
        if (core_lat == CORE_LAT) begin
          core_done <= 1'b1;
          core_wcnt <= 5;
        end else begin
          core_lat <= core_lat + 1;
        end
      end
      // Word k is presented on the edge after the previous one so that the
      // first word is stable at the second edge after the read trigger.
      if (!m_start_read_n) begin
        rd_idx <= 0;
      end else if (rd_idx < 4) begin
        aes_dword_out <= core_res[127 - 32*rd_idx -: 32];
        rd_idx        <= rd_idx + 1;
      end
    end
  end

  int read_pulses  = 0;
  int start_pulses = 0;
  always @(posedge clk) begin
    if (!m_start_read_n) read_pulses <= read_pulses + 1;
    if (!m_start_n)      start_pulses <= start_pulses + 1;
  end

  // ---------------- checking helpers ----------------
  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_in_ready"},    m_in_ready, 1'b1);
    check({tag, "_out_valid"},   m_out_valid, 1'b0);
    check({tag, "_out_block"},   m_out_block, '0);
    check({tag, "_start_n"},     m_start_n, 1'b1);
    check({tag, "_start_read"},  m_start_read_n, 1'b1);
    check({tag, "_dword_in"},    m_dword_in, 32'h0);
    check({tag, "_busy"},        m_busy, 1'b0);
    check({tag, "_timeout_err"}, m_timeout_err, 1'b0);
  endtask

  task automatic wait_out_valid(input string tag, input int max_cycles);
    int n = 0;
    while (m_out_valid !== 1'b1 && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    check(tag, m_out_valid, 1'b1);
  endtask

  task automatic wait_read_req(input string tag, input int max_cycles);
    int n = 0;
    while (m_start_read_n !== 1'b0 && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    check(tag, m_start_read_n, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int rp;
    reset = 1'b0; in_valid = 1'b0; in_block = '0; out_ready = 1'b0;
    done_enable = 1'b1; done_force = 1'b0; done_force_val = 1'b0; sel_long = 1'b0;
    #1 reset = 1'b1;
    @(negedge clk); @(negedge clk);
    check_reset_vals("reset");

    // NIST vector; handshake on the first edge after reset release
    reset = 1'b0; in_valid = 1'b1; in_block = B_ONES;
    @(negedge clk);
    check("nist_busy", m_busy, 1'b1);
    check("nist_in_ready_low", m_in_ready, 1'b0);
    check("nist_start_n_c0", m_start_n, 1'b0);
    check("nist_word0", m_dword_in, 32'hffffffff);
    in_valid = 1'b0; in_block = B_JUNK;
    for (int k = 1; k < 4; k++) begin
      @(negedge clk);
      check("nist_start_n_ck", m_start_n, 1'b1);
      check("nist_wordk", m_dword_in, 32'hffffffff);
    end
    @(negedge clk);
    check("nist_dword_zero_wait", m_dword_in, 32'h0);
    check("nist_one_start", start_pulses, 1);
    wait_out_valid("nist_out_valid", 100);
    check("nist_out_block", m_out_block, NIST_CT);
    check("nist_one_read", read_pulses, 1);

    // backpressure for 20 cycles
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("bp_out_valid", m_out_valid, 1'b1);
      check("bp_out_block", m_out_block, NIST_CT);
      check("bp_in_ready", m_in_ready, 1'b0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_valid", m_out_valid, 1'b0);
    check("bp_release_in_ready", m_in_ready, 1'b1);
    check("bp_release_busy", m_busy, 1'b0);
    out_ready = 1'b0;

    // back-to-back with in_valid held high
    in_valid = 1'b1; in_block = B_ONES;
    wait_out_valid("b2b1_out_valid", 100);
    check("b2b1_out_block", m_out_block, NIST_CT);
    check("b2b1_in_ready", m_in_ready, 1'b0);
    in_block = B_SEQ; out_ready = 1'b1;
    @(negedge clk);
    check("b2b_hs_valid", m_out_valid, 1'b0);
    check("b2b_hs_in_ready", m_in_ready, 1'b1);
    @(negedge clk);
    check("b2b2_accepted", m_in_ready, 1'b0);
    check("b2b2_start_n", m_start_n, 1'b0);
    check("b2b2_word0", m_dword_in, 32'h00112233);
    in_valid = 1'b0;
    @(negedge clk); check("b2b2_word1", m_dword_in, 32'h44556677);
    @(negedge clk); check("b2b2_word2", m_dword_in, 32'h8899aabb);
    @(negedge clk); check("b2b2_word3", m_dword_in, 32'hccddeeff);
    wait_out_valid("b2b2_out_valid", 100);
    check("b2b2_out_block", m_out_block, SEQ_CT);
    @(negedge clk);
    check("b2b2_valid_drop", m_out_valid, 1'b0);
    out_ready = 1'b0;

    // timeout: core never signals done
    done_enable = 1'b0; in_valid = 1'b1; in_block = B_SEQ; rp = read_pulses;
    @(negedge clk);
    check("to_busy", m_busy, 1'b1);
    in_valid = 1'b0;
    repeat (35) @(negedge clk);
    check("to_not_yet", m_timeout_err, 1'b0);
    check("to_not_yet_busy", m_busy, 1'b1);
    @(negedge clk);
    check("to_err", m_timeout_err, 1'b1);
    check("to_in_ready", m_in_ready, 1'b1);
    check("to_idle", m_busy, 1'b0);
    check("to_no_valid", m_out_valid, 1'b0);
    check("to_no_read", read_pulses, rp);
    repeat (3) @(negedge clk);
    check("to_sticky", m_timeout_err, 1'b1);
    done_enable = 1'b1; in_valid = 1'b1; in_block = B_ONES;
    @(negedge clk);
    check("to_cleared", m_timeout_err, 1'b0);
    in_valid = 1'b0; out_ready = 1'b1;
    wait_out_valid("to_next_valid", 100);
    check("to_next_block", m_out_block, NIST_CT);
    @(negedge clk);
    out_ready = 1'b0;

    // reset after the second read capture
    in_valid = 1'b1; in_block = B_ONES;
    @(negedge clk);
    in_valid = 1'b0;
    wait_read_req("rst_read_req", 100);
    repeat (4) @(negedge clk);
    check("rst_in_read", m_busy, 1'b1);
    #1 reset = 1'b1;
    #1;
    check_reset_vals("rst_mid");
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("rst_no_valid", m_out_valid, 1'b0);
    end
    in_valid = 1'b1; in_block = B_SEQ; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    wait_out_valid("rst_next_valid", 100);
    check("rst_next_block", m_out_block, SEQ_CT);
    @(negedge clk);
    out_ready = 1'b0;

    // stale done on the long-timeout instance
    sel_long = 1'b1; done_force = 1'b1; done_force_val = 1'b1;
    in_valid = 1'b1; in_block = B_SEQ;
    @(negedge clk);
    in_valid = 1'b0; rp = read_pulses;
    repeat (4) @(negedge clk);
    check("stale_in_wait", m_dword_in, 32'h0);
    check("stale_busy", m_busy, 1'b1);
    repeat (3) @(negedge clk);
    done_force_val = 1'b0;
    repeat (100) @(negedge clk);
    check("stale_no_read", read_pulses, rp);
    check("stale_wait_busy", m_busy, 1'b1);
    done_force_val = 1'b1;
    @(negedge clk);
    check("stale_reg_delay", m_start_read_n, 1'b1);
    @(negedge clk);
    check("stale_pulse", m_start_read_n, 1'b0);
    @(negedge clk);
    check("stale_pulse_end", m_start_read_n, 1'b1);
    check("stale_one_read", read_pulses, rp + 1);
    done_force = 1'b0; out_ready = 1'b1;
    wait_out_valid("stale_out_valid", 100);
    check("stale_out_block", m_out_block, SEQ_CT);
    @(negedge clk);
    out_ready = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
